// File: rtl/alu_pkg.sv
// Shared op codes and FSM state type for the ALU and its two-requester arbiter.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; ADD and SUB wrap modulo 2^DATA_W with no carry out.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_sel,
    output logic [DATA_W-1:0] o_result
);

    // Decode the op code into the selected function of the operands.
    always_comb begin
        o_result = '0;
        unique case (i_sel)
            OP_ADD:   o_result = i_a + i_b;
            OP_SUB:   o_result = i_a - i_b;
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_NOTA:  o_result = ~i_a;
            OP_PASSA: o_result = i_a;
            OP_PASSB: o_result = i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_sel;
    logic              r_id;
    logic [DATA_W-1:0] r_result;
    logic              r_rsp_id;
    logic              w_gnt_id;
    logic              w_take;
    logic [DATA_W-1:0] w_alu_result;

    // Tie goes to the requester not granted last; otherwise the sole valid one wins.
    assign w_gnt_id = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    // Accept only in IDLE and never while reset is asserted.
    assign w_take   = rst_n && (r_state == StIdle) && (req0_valid || req1_valid);

    assign req0_ready = w_take && !w_gnt_id;
    assign req1_ready = w_take && w_gnt_id;
    assign rsp_valid  = (r_state == StResp);
    assign rsp_result = r_result;
    assign rsp_id     = r_rsp_id;
    assign busy       = (r_state != StIdle);

    // ALU sees only the captured operands, never the live request buses.
    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sel    (r_sel),
        .o_result (w_alu_result)
    );

    // Next-state logic: IDLE -> EXEC on any request, EXEC -> RESP, RESP -> IDLE on rsp_ready.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (req0_valid || req1_valid) w_state_next = StExec;
            StExec:  w_state_next = StResp;
            StResp:  if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State, request capture, grant pointer and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_last   <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_rsp_id <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_a    <= w_gnt_id ? req1_a : req0_a;
                r_b    <= w_gnt_id ? req1_b : req0_b;
                r_sel  <= w_gnt_id ? req1_sel : req0_sel;
                r_id   <= w_gnt_id;
                r_last <= w_gnt_id;
            end
            if (r_state == StExec) begin
                r_result <= w_alu_result;
                r_rsp_id <= r_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus queues expected responses, a monitor checks them.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned DATA_W = 4;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid = 1'b0;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a = '0;
    logic [DATA_W-1:0] req0_b = '0;
    logic [2:0]        req0_sel = '0;
    logic              req1_valid = 1'b0;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a = '0;
    logic [DATA_W-1:0] req1_b = '0;
    logic [2:0]        req1_sel = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              busy;

    exp_t exp_q[$];
    int   hs_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    alu_arbiter #(
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_total++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic       m_prev_valid = 1'b0;
    logic       m_prev_rdy = 1'b0;
    logic [3:0] m_last_res = '0;
    logic       m_last_id = 1'b0;
    exp_t       m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_valid = 1'b0;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) hs_q.push_back(cyc);
            if (busy) check("ready_while_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
            if (rsp_valid && !m_prev_valid) begin
                if (hs_q.size() == 0) fail("rsp_without_handshake", "got response, required none");
                else check("latency", cyc - hs_q.pop_front(), 32'd2);
            end
            if (rsp_valid && m_prev_valid && !m_prev_rdy) begin
                check("hold_result", rsp_result, m_last_res);
                check("hold_id", rsp_id, m_last_id);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_rsp", "got response, required none");
                end else begin
                    m_e = exp_q.pop_front();
                    check("rsp_id", rsp_id, m_e.id);
                    check("rsp_result", rsp_result, m_e.res);
                end
            end
            m_prev_valid = rsp_valid;
            m_prev_rdy   = rsp_ready;
            m_last_res   = rsp_result;
            m_last_id    = rsp_id;
        end
    end

    task automatic drive(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
        end
    endtask

    // Present one op, hold it until accepted, then drop valid just after the accepting edge.
    task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input logic [3:0] res);
        bit got = 1'b0;
        exp_q.push_back(exp_t'{id: id, res: res});
        drive(id, 1'b1, a, b, sel);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) fail("issue_timeout", "got ready=0, required ready=1");
        @(posedge clk);
        #1;
        drive(id, 1'b0, a, b, sel);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) fail("drain_timeout", "got pending responses, required none");
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sweep_exp [8];
    int         n_hs;
    bit         seen;

    initial begin
        sweep_exp = '{4'd8, 4'd2, 4'd1, 4'd7, 4'd6, 4'd10, 4'd5, 4'd3};

        // Reset with a request pending: nothing may be accepted.
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready0", req0_ready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_result", rsp_result, 4'd0);
        check("reset_id", rsp_id, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;

        // Single op.
        issue(1'b0, 4'b0101, 4'b0011, OP_ADD, 4'b1000);
        drain();

        // Op sweep via requester 1.
        for (int s = 0; s < 8; s++) begin
            issue(1'b1, 4'b0101, 4'b0011, 3'(s), sweep_exp[s]);
        end
        drain();

        // Wrap-around.
        issue(1'b0, 4'b1111, 4'b0001, OP_ADD, 4'b0000);
        issue(1'b0, 4'b0000, 4'b0001, OP_SUB, 4'b1111);
        drain();

        // Backpressure with requester 1 waiting during RESP.
        rsp_ready = 1'b0;
        issue(1'b0, 4'b1001, 4'b0011, OP_AND, 4'b0001);
        exp_q.push_back(exp_t'{id: 1'b1, res: 4'd6});
        drive(1'b1, 1'b1, 4'd2, 4'd4, OP_OR);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) fail("bp_rsp_timeout", "got rsp_valid=0, required 1");
        repeat (4) @(negedge clk);
        check("bp_still_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_resume_ready1", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'd2, 4'd4, OP_OR);
        drain();

        // Reset while requester 0's op is in EXEC: op discarded, pointer restored.
        drive(1'b0, 1'b1, 4'd1, 4'd1, OP_ADD);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        if (!seen) fail("rst_exec_accept", "got ready=0, required ready=1");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec_ready0", req0_ready, 1'b0);
        check("rst_exec_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_q.delete();

        // Contention straight after reset: grants must alternate 0,1,0,1.
        exp_q.push_back(exp_t'{id: 1'b0, res: 4'd3});
        exp_q.push_back(exp_t'{id: 1'b1, res: 4'd6});
        exp_q.push_back(exp_t'{id: 1'b0, res: 4'd3});
        exp_q.push_back(exp_t'{id: 1'b1, res: 4'd6});
        drive(1'b0, 1'b1, 4'd1, 4'd2, OP_ADD);
        drive(1'b1, 1'b1, 4'd7, 4'd1, OP_SUB);
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_tie_grant0", {30'd0, req0_ready, req1_ready}, 32'd2);
        n_hs = 0;
        for (int i = 0; i < 40 && n_hs < 4; i++) begin
            if (i > 0) @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) n_hs++;
        end
        if (n_hs < 4) fail("contention_timeout", "got fewer than 4 grants, required 4");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'd1, 4'd2, OP_ADD);
        drive(1'b1, 1'b0, 4'd7, 4'd1, OP_SUB);
        drain();
        repeat (4) @(negedge clk);
        check("final_idle_rsp_valid", rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required completion");
        $fatal(1, "watchdog");
    end

endmodule
